// File: rtl/dbg_hex_monitor_if.sv
// Debug monitor bus: channel capture inputs, display select controls and
// the registered display/status outputs.
interface dbg_hex_monitor_if #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 16
);
    localparam int NUM_DIGITS = DATA_WIDTH / 4;
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH*DATA_WIDTH-1:0] ch_data;
    logic [NUM_CH-1:0]            ch_valid;
    logic [CH_W-1:0]              sel;
    logic [1:0]                   mode;
    logic                         clear;
    logic [NUM_DIGITS*7-1:0]      hex_out;
    logic [CH_W-1:0]              cur_ch;
    logic [NUM_CH-1:0]            sticky_upd;
    logic [CNT_W-1:0]             upd_count;

    modport master (
        output ch_data, ch_valid, sel, mode, clear,
        input  hex_out, cur_ch, sticky_upd, upd_count
    );

    modport slave (
        input  ch_data, ch_valid, sel, mode, clear,
        output hex_out, cur_ch, sticky_upd, upd_count
    );
endinterface

// File: rtl/dbg_hex_monitor.sv
// Multi-channel debug capture with seven-segment hex display of one channel.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_LIVE   | display follows sel (out-of-range sel shows channel 0)
// ST_FREEZE | display, cur_ch and upd_count held; capture keeps running
// ST_SCROLL | cur_ch advances every SCROLL_CYCLES clocks, wrapping to 0
module dbg_hex_monitor #(
    parameter int NUM_CH        = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int CNT_W         = 16,
    parameter int SCROLL_CYCLES = 50000000
) (
    input  logic            clk,
    input  logic            rst,
    dbg_hex_monitor_if.slave bus
);
    localparam int NUM_DIGITS = DATA_WIDTH / 4;
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMR_W      = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;

    localparam logic [1:0] ST_LIVE   = 2'd0;
    localparam logic [1:0] ST_FREEZE = 2'd1;
    localparam logic [1:0] ST_SCROLL = 2'd2;

    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SCROLL_CYCLES - 1);

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [DATA_WIDTH-1:0]   shadow [NUM_CH];
    logic [CNT_W-1:0]        cnt    [NUM_CH];
    logic [NUM_CH-1:0]       sticky_q;
    logic [1:0]              state_q, state_d;
    logic [CH_W-1:0]         cur_ch_q, cur_ch_next, sel_eff;
    logic [TMR_W-1:0]        tmr_q;
    logic [NUM_DIGITS*7-1:0] hex_q, hex_d;
    logic [CNT_W-1:0]        upd_q, cur_cnt;
    logic [DATA_WIDTH-1:0]   cur_data;

    // Shadow capture, saturating update counters and sticky flags; clear wins over strobes.
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow[k] <= '0;
                cnt[k]    <= '0;
            end
            sticky_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.ch_valid[k]) begin
                    shadow[k]   <= bus.ch_data[k*DATA_WIDTH +: DATA_WIDTH];
                    sticky_q[k] <= 1'b1;
                    if (cnt[k] != '1) begin
                        cnt[k] <= cnt[k] + 1'b1;
                    end
                end
            end
        end
    end

    // Next view state, effective select, scroll successor and decode of the displayed channel.
    always_comb begin
        case (bus.mode)
            2'b01:   state_d = ST_FREEZE;
            2'b10:   state_d = ST_SCROLL;
            default: state_d = ST_LIVE;
        endcase
        sel_eff     = (int'(bus.sel) < NUM_CH) ? bus.sel : '0;
        cur_ch_next = (cur_ch_q == CH_W'(NUM_CH - 1)) ? '0 : cur_ch_q + 1'b1;
        cur_data    = '0;
        cur_cnt     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cur_ch_q == CH_W'(k)) begin
                cur_data = shadow[k];
                cur_cnt  = cnt[k];
            end
        end
        hex_d = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            hex_d[d*7 +: 7] = seg7(cur_data[d*4 +: 4]);
        end
    end

    // View FSM, scroll down-counter and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_LIVE;
            cur_ch_q <= '0;
            tmr_q    <= '0;
            hex_q    <= {NUM_DIGITS{7'b1000000}};
            upd_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_d)
                ST_FREEZE: begin
                    tmr_q <= '0;
                end
                ST_SCROLL: begin
                    hex_q <= hex_d;
                    upd_q <= cur_cnt;
                    // tmr_q counts the clocks remaining before the next channel step
                    if (state_q != ST_SCROLL) begin
                        tmr_q <= TMR_RELOAD;
                    end else if (tmr_q == '0) begin
                        tmr_q    <= TMR_RELOAD;
                        cur_ch_q <= cur_ch_next;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                default: begin
                    hex_q    <= hex_d;
                    upd_q    <= cur_cnt;
                    cur_ch_q <= sel_eff;
                    tmr_q    <= '0;
                end
            endcase
        end
    end

    assign bus.hex_out    = hex_q;
    assign bus.cur_ch     = cur_ch_q;
    assign bus.sticky_upd = sticky_q;
    assign bus.upd_count  = upd_q;
endmodule
